// File: rtl/regfile_pkg.sv
// Shared constants and types for the LEGv8 register file write side.
package regfile_pkg;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned ZERO_REG = 31;
  localparam int unsigned DATA_W   = 64;

  typedef logic [DATA_W-1:0]        reg_word_t;
  typedef reg_word_t [NUM_REGS-1:0] reg_array_t;

endpackage : regfile_pkg

// File: rtl/decoder5_32.sv
// Hierarchical 5:32 decoder: a 2:4 group select combined with a 3:8 line select.
module decoder5_32 (
  input  logic       en,
  input  logic [4:0] addr,
  output logic [31:0] y
);

  logic [3:0] hi;
  logic [7:0] lo;

  // 2:4 stage picks the group of eight; gating here keeps y clean when addr is X
  always_comb begin
    hi = '0;
    if (en) begin
      hi[addr[4:3]] = 1'b1;
    end
  end

  // 3:8 stage picks the line within the group
  always_comb begin
    lo = '0;
    lo[addr[2:0]] = 1'b1;
  end

  // Combine group and line selects into the one-hot output
  always_comb begin
    y = '0;
    for (int g = 0; g < 4; g++) begin
      for (int k = 0; k < 8; k++) begin
        y[g*8 + k] = hi[g] & lo[k];
      end
    end
  end

endmodule : decoder5_32

// File: rtl/en_dff_bank.sv
// WIDTH-bit enable register: hold mux plus DFF per bit, synchronous clear.
module en_dff_bank #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Clear dominates; otherwise load on enable, else recirculate
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule : en_dff_bank

// File: rtl/regfile_write_port.sv
// Write side of the 32-entry LEGv8 register file; register ZERO_REG (XZR) reads 0.
module regfile_write_port
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH    = regfile_pkg::DATA_W,
  parameter int unsigned ZERO_REG = regfile_pkg::ZERO_REG
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             wr_en,
  input  logic [ADDR_W-1:0]                wr_addr,
  input  logic [WIDTH-1:0]                 wr_data,
  output logic [NUM_REGS-1:0][WIDTH-1:0]   regs_out,
  output logic [NUM_REGS-1:0]              wr_onehot
);

  logic [NUM_REGS-1:0] dec_y;

  decoder5_32 u_dec (
    .en   (wr_en),
    .addr (wr_addr),
    .y    (dec_y)
  );

  // XZR never gets an enable; decode is intentionally not gated by reset
  assign wr_onehot = dec_y & ~(NUM_REGS'(1) << ZERO_REG);

  // One enable bank per architectural register; XZR is a constant
  for (genvar i = 0; i < int'(NUM_REGS); i++) begin : g_reg
    if (i == int'(ZERO_REG)) begin : g_zero
      assign regs_out[i] = '0;
    end else begin : g_bank
      en_dff_bank #(.WIDTH(WIDTH)) u_bank (
        .clk   (clk),
        .reset (reset),
        .en    (wr_onehot[i]),
        .d     (wr_data),
        .q     (regs_out[i])
      );
    end
  end

endmodule : regfile_write_port
